// File: rtl/delta_nn.sv
// ---------------------------------------------------------------------------
// delta_nn : backpropagation error terms for a one-hidden-layer sigmoid net.
//
// Computes, per output neuron k, the output delta d[k] and the cost c[k],
// and per hidden neuron j the back-propagated hidden delta e[j]. All values
// are signed Q8.24. Two-stage pipeline, one vector per clock, no backpressure.
//
// Build option:
//   DELTA_NN_COST_EN - when defined the cost datapath is built; otherwise
//                      o_cost is tied to zero and no cost logic exists.
//
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   i_valid  : input vector valid
//   i_hd_a   : hidden activations h[j], slot j at [j*WIDTH +: WIDTH]
//   i_out_w  : weights w[j][k], slot j*N_OUT+k
//   i_out_a  : output activations a[k], slot k
//   i_t      : targets t[k], slot k
//   o_valid  : outputs valid (2 cycles after i_valid)
//   o_cost   : cost c[k], slot k
//   o_dlto   : output delta d[k], slot k
//   o_dlth   : hidden delta e[j], slot j
// ---------------------------------------------------------------------------
module delta_nn #(
    parameter int N_IN   = 2,
    parameter int N_HL_P = 3,
    parameter int N_OUT  = 2,
    parameter int WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [N_HL_P*WIDTH-1:0]       i_hd_a,
    input  logic [N_HL_P*N_OUT*WIDTH-1:0] i_out_w,
    input  logic [N_OUT*WIDTH-1:0]        i_out_a,
    input  logic [N_OUT*WIDTH-1:0]        i_t,
    output logic                          o_valid,
    output logic [N_OUT*WIDTH-1:0]        o_cost,
    output logic [N_OUT*WIDTH-1:0]        o_dlto,
    output logic [N_HL_P*WIDTH-1:0]       o_dlth
);

    localparam int FRAC = 24;
    localparam int N_W  = N_HL_P * N_OUT;
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);

    // N_IN has no datapath role; it is referenced here only so the parameter
    // list stays compatible with the surrounding network blocks.
    if (N_IN < 1) begin : g_n_in_unused
    end

    // Q8.24 multiply: full signed product, arithmetic shift (floor), wrap.
    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y
    );
        logic signed [2*WIDTH-1:0] p;
        p = x * y;
        p = p >>> FRAC;
        return p[WIDTH-1:0];
    endfunction

    // ---------------- input unpacking ----------------
    logic signed [WIDTH-1:0] w_h   [N_HL_P];
    logic signed [WIDTH-1:0] w_w   [N_W];
    logic signed [WIDTH-1:0] w_a   [N_OUT];
    logic signed [WIDTH-1:0] w_t   [N_OUT];
    logic signed [WIDTH-1:0] w_err [N_OUT];
    logic signed [WIDTH-1:0] w_d   [N_OUT];
    logic signed [WIDTH-1:0] w_hp  [N_HL_P];
    logic signed [WIDTH-1:0] w_s   [N_HL_P];
    logic signed [WIDTH-1:0] w_e   [N_HL_P];

    // ---------------- pipeline registers ----------------
    logic                    r_v1;
    logic                    r_v2;
    logic signed [WIDTH-1:0] r_d1  [N_OUT];
    logic signed [WIDTH-1:0] r_d2  [N_OUT];
    logic signed [WIDTH-1:0] r_hp1 [N_HL_P];
    logic signed [WIDTH-1:0] r_w1  [N_W];
    logic signed [WIDTH-1:0] r_e2  [N_HL_P];

    // Valid shift: advances every cycle so gaps propagate with fixed latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
        end
    end

    // ---------------- per output neuron ----------------
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
        assign w_a[gi]   = $signed(i_out_a[gi*WIDTH +: WIDTH]);
        assign w_t[gi]   = $signed(i_t[gi*WIDTH +: WIDTH]);
        assign w_err[gi] = w_a[gi] - w_t[gi];
        assign w_d[gi]   = fx_mul(fx_mul(w_err[gi], w_a[gi]), ONE - w_a[gi]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_d1[gi] <= '0;
                r_d2[gi] <= '0;
            end else begin
                if (i_valid)
                    r_d1[gi] <= w_d[gi];
                if (r_v1)
                    r_d2[gi] <= r_d1[gi];
            end
        end

        assign o_dlto[gi*WIDTH +: WIDTH] = r_d2[gi];
    end

`ifdef DELTA_NN_COST_EN
    logic signed [WIDTH-1:0] w_c  [N_OUT];
    logic signed [WIDTH-1:0] r_c1 [N_OUT];
    logic signed [WIDTH-1:0] r_c2 [N_OUT];

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_cost
        assign w_c[gi] = fx_mul(w_err[gi], w_err[gi]) >>> 1;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_c1[gi] <= '0;
                r_c2[gi] <= '0;
            end else begin
                if (i_valid)
                    r_c1[gi] <= w_c[gi];
                if (r_v1)
                    r_c2[gi] <= r_c1[gi];
            end
        end

        assign o_cost[gi*WIDTH +: WIDTH] = r_c2[gi];
    end
`else
    assign o_cost = '0;
`endif

    // ---------------- weights, captured alongside stage-1 deltas ----------------
    for (genvar gi = 0; gi < N_W; gi++) begin : g_w
        assign w_w[gi] = $signed(i_out_w[gi*WIDTH +: WIDTH]);

        always_ff @(posedge clk) begin
            if (rst)
                r_w1[gi] <= '0;
            else if (i_valid)
                r_w1[gi] <= w_w[gi];
        end
    end

    // ---------------- per hidden neuron ----------------
    for (genvar gi = 0; gi < N_HL_P; gi++) begin : g_hid
        assign w_h[gi]  = $signed(i_hd_a[gi*WIDTH +: WIDTH]);
        assign w_hp[gi] = fx_mul(w_h[gi], ONE - w_h[gi]);

        // Weighted sum of stage-1 deltas, accumulated in ascending k so the
        // wrap behaviour matches the reference model bit for bit.
        always_comb begin
            w_s[gi] = '0;
            for (int k = 0; k < N_OUT; k++)
                w_s[gi] = w_s[gi] + fx_mul(r_w1[gi*N_OUT + k], r_d1[k]);
        end

        assign w_e[gi] = fx_mul(w_s[gi], r_hp1[gi]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_hp1[gi] <= '0;
                r_e2[gi]  <= '0;
            end else begin
                if (i_valid)
                    r_hp1[gi] <= w_hp[gi];
                if (r_v1)
                    r_e2[gi] <= w_e[gi];
            end
        end

        assign o_dlth[gi*WIDTH +: WIDTH] = r_e2[gi];
    end

    assign o_valid = r_v2;

endmodule

// File: tb/tb_delta_nn.sv
// ---------------------------------------------------------------------------
// tb_delta_nn : self-checking bench for delta_nn (default parameters).
// Expected results come from a bench-side Q8.24 model and are queued when a
// vector is driven; a negedge monitor pops and compares them when o_valid is
// seen, checks o_valid timing against a 2-cycle delay of the driven i_valid,
// checks that outputs hold between results and are zero after reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_delta_nn;

    localparam int NH = 3;
    localparam int NO = 2;
    localparam int W  = 32;
    localparam logic [31:0] ONE = 32'h0100_0000;

    typedef struct {
        logic [NO*W-1:0] cost;
        logic [NO*W-1:0] dlto;
        logic [NH*W-1:0] dlth;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid;
    logic [NH*W-1:0]      i_hd_a;
    logic [NH*NO*W-1:0]   i_out_w;
    logic [NO*W-1:0]      i_out_a;
    logic [NO*W-1:0]      i_t;
    logic                 o_valid;
    logic [NO*W-1:0]      o_cost;
    logic [NO*W-1:0]      o_dlto;
    logic [NH*W-1:0]      o_dlth;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t last;
    bit   ev1 = 1'b0, ev2 = 1'b0, rst_at_edge = 1'b0;

    delta_nn #(.N_IN(2), .N_HL_P(NH), .N_OUT(NO), .WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_hd_a  (i_hd_a),
        .i_out_w (i_out_w),
        .i_out_a (i_out_a),
        .i_t     (i_t),
        .o_valid (o_valid),
        .o_cost  (o_cost),
        .o_dlto  (o_dlto),
        .o_dlth  (o_dlth)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'(signed'(x)) * longint'(signed'(y));
        p = p >>> 24;
        return p[31:0];
    endfunction

    function automatic exp_t model(input logic [NH*W-1:0] hd, input logic [NH*NO*W-1:0] wv,
                                   input logic [NO*W-1:0] a, input logic [NO*W-1:0] t);
        exp_t        r;
        logic [31:0] d [NO];
        logic [31:0] err, c, s, h, hp, ak;
        for (int k = 0; k < NO; k++) begin
            ak   = a[k*W +: W];
            err  = ak - t[k*W +: W];
            d[k] = fmul(fmul(err, ak), ONE - ak);
            c    = fmul(err, err);
            c    = {c[31], c[31:1]};
            r.dlto[k*W +: W] = d[k];
`ifdef DELTA_NN_COST_EN
            r.cost[k*W +: W] = c;
`else
            r.cost[k*W +: W] = 32'h0;
`endif
        end
        for (int j = 0; j < NH; j++) begin
            s = 32'h0;
            for (int k = 0; k < NO; k++)
                s = s + fmul(wv[(j*NO+k)*W +: W], d[k]);
            h  = hd[j*W +: W];
            hp = fmul(h, ONE - h);
            r.dlth[j*W +: W] = fmul(s, hp);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one vector for one edge and queue its expected result.
    task automatic send(input logic [NH*W-1:0] hd, input logic [NH*NO*W-1:0] wv,
                        input logic [NO*W-1:0] a, input logic [NO*W-1:0] t);
        i_hd_a  = hd;
        i_out_w = wv;
        i_out_a = a;
        i_t     = t;
        i_valid = 1'b1;
        sb.push_back(model(hd, wv, a, t));
        $display("send: h=%h a=%h t=%h", hd, a, t);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference timing: o_valid is i_valid delayed two edges, cleared by reset.
    always @(posedge clk) begin
        rst_at_edge <= rst;
        if (rst) begin
            ev1 <= 1'b0;
            ev2 <= 1'b0;
        end else begin
            ev1 <= i_valid;
            ev2 <= ev1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge) begin
            chk("rst_valid", 192'(o_valid), 192'(1'b0));
            chk("rst_outs", {o_cost, o_dlto, o_dlth}, '0);
            last.cost = '0;
            last.dlto = '0;
            last.dlth = '0;
        end else begin
            chk("valid_timing", 192'(o_valid), 192'(ev2));
            if (o_valid) begin
                chk("sb_nonempty", 192'(sb.size() != 0), 192'(1'b1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("cost", 192'(o_cost), 192'(e.cost));
                    chk("dlto", 192'(o_dlto), 192'(e.dlto));
                    chk("dlth", 192'(o_dlth), 192'(e.dlth));
                    $display("result: cost=%h dlto=%h dlth=%h", o_cost, o_dlto, o_dlth);
                    last = e;
                end
            end else begin
                chk("hold", {o_cost, o_dlto, o_dlth}, {last.cost, last.dlto, last.dlth});
            end
        end
    end

    initial begin
        logic [NH*W-1:0]    hd;
        logic [NH*NO*W-1:0] wv;
        logic [NO*W-1:0]    a, t;
        int                 guard;

        last.cost = '0;
        last.dlto = '0;
        last.dlth = '0;

        // Reset for two edges with i_valid high: reset must win.
        rst     = 1'b1;
        i_valid = 1'b1;
        i_hd_a  = {NH{32'h0080_0000}};
        i_out_w = {NH{32'h0080_0000, 32'h0100_0000}};
        i_out_a = {2{32'h0080_0000}};
        i_t     = {32'h0, ONE};
        idle(2);
        rst     = 1'b0;
        i_valid = 1'b0;
        idle(2);

        // Exact-value vector.
        send({NH{32'h0080_0000}}, {NH{32'h0080_0000, 32'h0100_0000}},
             {32'h0080_0000, 32'h0080_0000}, {32'h0000_0000, ONE});
        idle(3);
        chk("exact_d", 192'(last.dlto), 192'({32'h0020_0000, 32'hFFE0_0000}));
        chk("exact_e", 192'(last.dlth), 192'({NH{32'hFFFC_0000}}));

        // Realistic vector.
        send(96'h00e92147_00ef2148_00f37fff,
             192'h01199999_00800000_00333332_014ccccc_00333332_00b33333,
             64'h00a86d19_00bd0f28, 64'h00000000_01000000);
        idle(3);

        // Zero error.
        send(96'h0040_0000_00c0_0000_0080_0000, {NH{32'h0100_0000, 32'hFF00_0000}},
             {ONE, ONE}, {ONE, ONE});
        idle(3);

        // Streaming: four distinct random vectors back to back.
        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < NH; j++)
                hd[j*W +: W] = 32'($urandom_range(0, 32'h0100_0000));
            for (int i = 0; i < NH*NO; i++)
                wv[i*W +: W] = 32'($urandom_range(0, 32'h0200_0000)) - 32'h0100_0000;
            for (int k = 0; k < NO; k++) begin
                a[k*W +: W] = 32'($urandom_range(0, 32'h0100_0000));
                t[k*W +: W] = (($urandom_range(0, 1)) != 0) ? ONE : 32'h0;
            end
            send(hd, wv, a, t);
        end
        idle(4);

        // Gaps: i_valid pattern 1,0,0,1.
        send({NH{32'h0060_0000}}, {NH{32'h0040_0000, 32'hFFC0_0000}},
             {32'h0030_0000, 32'h00D0_0000}, {32'h0, ONE});
        idle(2);
        send({NH{32'h00A0_0000}}, {NH{32'h0120_0000, 32'h0050_0000}},
             {32'h00F0_0000, 32'h0010_0000}, {ONE, 32'h0});
        idle(4);

        // Reset with a vector in flight: it must be discarded.
        send({NH{32'h0080_0000}}, {NH{32'h0080_0000, 32'h0100_0000}},
             {32'h0080_0000, 32'h0080_0000}, {32'h0000_0000, ONE});
        rst = 1'b1;
        sb.delete();
        idle(2);
        rst = 1'b0;
        idle(3);

        // Recovery: first result two cycles after the next i_valid.
        send({NH{32'h0070_0000}}, {NH{32'h00C0_0000, 32'h0020_0000}},
             {32'h0090_0000, 32'h0050_0000}, {ONE, 32'h0});

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        idle(2);
        chk("drain", 192'(sb.size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
